// File: rtl/pipe_ctrl_if.sv
// Request/hold bundle between the pipeline stages and the sequencing controller.
interface pipe_ctrl_if;
  logic        if_stallreq;
  logic        id_load_use;
  logic        ex_div_start;
  logic        mem_stallreq;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_busy;
  logic        div_done;

  modport master (
    input  if_stallreq, id_load_use, ex_div_start, mem_stallreq,
    input  exc_req, eret_req, epc,
    output stall, flush, new_pc, div_busy, div_done
  );

  modport slave (
    output if_stallreq, id_load_use, ex_div_start, mem_stallreq,
    output exc_req, eret_req, epc,
    input  stall, flush, new_pc, div_busy, div_done
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencing: hold vector, exception/ERET flush + redirect,
// and the multi-cycle divider occupancy in EX.
module pipe_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_ctrl_if.master      bus
);
  localparam int CNT_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic             redirect;
  logic             div_stall;

  assign redirect = bus.exc_req | bus.eret_req;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d  = FLUSH;
          new_pc_d = bus.exc_req ? EXC_VECTOR : bus.epc;
        end else if (bus.ex_div_start && !bus.mem_stallreq) begin
          state_d = DIV;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      DIV: begin
        // A committed exception or ERET abandons the divide outright.
        if (redirect) begin
          state_d  = FLUSH;
          cnt_d    = '0;
          new_pc_d = bus.exc_req ? EXC_VECTOR : bus.epc;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!bus.mem_stallreq) begin
          state_d = IDLE;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_stall = (state_q == IDLE && bus.ex_div_start) ||
                     (state_q == DIV && cnt_q != '0);

  // Reset forces an all-clear hold vector even while requests are still asserted.
  always_comb begin
    bus.stall = 6'b000000;
    if (resetn || state_q == FLUSH) bus.stall = 6'b000000;
    else if (bus.mem_stallreq)      bus.stall = 6'b011111;
    else if (div_stall)             bus.stall = 6'b001111;
    else if (bus.id_load_use)       bus.stall = 6'b000111;
    else if (bus.if_stallreq)       bus.stall = 6'b000011;
  end

  assign bus.flush    = (state_q == FLUSH);
  assign bus.new_pc   = new_pc_q;
  assign bus.div_busy = (state_q == DIV);
  assign bus.div_done = (state_q == DIV) && (cnt_q == '0);
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage CPU. It collects stall and exception requests from IF, ID, EX and MEM, and drives the per-boundary hold vector consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also drives the one-cycle flush and redirect PC on exception entry and return, and it sequences the multi-cycle divider occupying EX.

## Interface
Parameters:
- DIV_CYCLES, 32, divider iterations; legal range 2..256; counter width is clog2(DIV_CYCLES).
- EXC_VECTOR, 32'hBFC00380, redirect PC on exception entry.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-high reset (1 = reset), despite the name.
- if_stallreq  in  1  fetch not ready.
- id_load_use  in  1  load-use hazard detected in ID.
- ex_div_start  in  1  valid DIV/DIVU instruction in EX.
- mem_stallreq  in  1  data access not ready.
- exc_req  in  1  exception committed in MEM.
- eret_req  in  1  ERET committed in MEM.
- epc  in  32  return address for ERET.
- stall  out  6  hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
- flush  out  1  clear all pipeline registers to bubbles.
- new_pc  out  32  redirect target, valid while flush=1.
- div_busy  out  1  divider iterating.
- div_done  out  1  divider result valid, EX may advance.

## Operation
- States: IDLE, DIV, FLUSH; 2-bit state register plus down-counter cnt.
- stall is combinational from inputs, state and cnt. Priority is highest first:
  - state FLUSH → 000000.
  - mem_stallreq → 011111.
  - div stall → 001111. This applies in IDLE when ex_div_start=1, and in DIV when cnt≠0.
  - id_load_use → 000111.
  - if_stallreq → 000011.
  - else 000000.
- IDLE transitions:
  - exc_req or eret_req → FLUSH. new_pc is registered as EXC_VECTOR if exc_req, else epc. exc_req wins if both are set.
  - else ex_div_start=1 and mem_stallreq=0 → DIV, with cnt ← DIV_CYCLES−1.
  - ex_div_start with mem_stallreq=1 waits in IDLE. stall=011111 in that case.
- DIV:
  - cnt decrements every cycle while ≠0, independent of mem_stallreq.
  - At cnt=0: div_done=1. If mem_stallreq=0, go to IDLE. Else stay with div_done held.
  - exc_req/eret_req in DIV abort the divide: go to FLUSH, and div_done is not raised.
- FLUSH: lasts exactly one cycle, then IDLE. exc_req/eret_req are ignored in FLUSH.
- div_busy = (state==DIV). div_done is combinational: (state==DIV && cnt==0).
- flush = (state==FLUSH). new_pc holds its last value outside FLUSH.

## Timing
- Reset (async assert, sync release): state IDLE, cnt 0, stall 000000, flush 0, new_pc 0, div_busy 0, div_done 0.
- Reset mid-DIV or mid-FLUSH returns to IDLE immediately; no div_done or flush pulse follows.
- Exception latency: exc_req high at edge N → flush=1 and new_pc valid during cycle N+1 → IDLE at N+2.
- Divide with no other requests, start cycle S:
  - stall=001111 in cycles S..S+DIV_CYCLES−1 (DIV_CYCLES cycles).
  - div_done=1 in cycle S+DIV_CYCLES.
  - EX occupancy is DIV_CYCLES+1 cycles.
- In the div_done cycle, ex_div_start is still high and does not restart the divider. A new divide can start no earlier than the cycle after return to IDLE.
- Simultaneous exc_req and ex_div_start in IDLE: FLUSH taken, divide not started.

## Test plan
- Reset: assert resetn mid-DIV (cnt=10) → all outputs 0 in the same cycle; after release, stall=000000 with no requests.
- Priority: mem_stallreq=1, id_load_use=1, if_stallreq=1 → stall=011111. Drop mem_stallreq → 000111. Drop id_load_use → 000011.
- Divide, DIV_CYCLES=32: ex_div_start held → 32 cycles of stall=001111, then 1 cycle div_done=1 with stall=000000, then IDLE.
- Divide end under mem stall: mem_stallreq=1 at cnt=0 for 3 cycles → div_done held 4 cycles, stall=011111 for the first 3; IDLE after release.
- Exception during DIV at cnt=5: exc_req=1 → next cycle flush=1, new_pc=32'hBFC00380, div_busy=0; div_done never asserted.
- ERET: eret_req=1, epc=32'h80001234 → next cycle flush=1, new_pc=32'h80001234. Simultaneous exc_req=1 with eret_req=1 → new_pc=32'hBFC00380.
